// File: rtl/fp_pkg.sv
// Shared types and helpers for double-precision result handling.
// Holds the result class enum, FIFO entry layout and the IEEE-754 classifier.
package fp_pkg;

  typedef enum logic [2:0] {
    FP_ZERO = 3'd0,
    FP_SUB  = 3'd1,
    FP_NORM = 3'd2,
    FP_INF  = 3'd3,
    FP_QNAN = 3'd4,
    FP_SNAN = 3'd5
  } fp_class_t;

  localparam logic [10:0] EXP_MAX        = 11'h7FF;
  localparam int          BYTES_PER_WORD = 8;

  typedef struct packed {
    logic [63:0] word;
    fp_class_t   cls;
  } fp_entry_t;

  // Sign never affects the class, so only exponent and fraction are taken.
  function automatic fp_class_t classify(input logic [10:0] ex, input logic [51:0] fr);
    fp_class_t c;
    if (ex == 11'd0) begin
      c = (fr == 52'd0) ? FP_ZERO : FP_SUB;
    end else if (ex == EXP_MAX) begin
      if (fr == 52'd0) begin
        c = FP_INF;
      end else if (fr[51]) begin
        c = FP_QNAN;
      end else begin
        c = FP_SNAN;
      end
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_result_collect_if.sv
// Byte-burst input, FIFO head output and error pulses of the result collector.
// The slave modport is the collector, the master modport is its environment.
interface fp_result_collect_if;
  import fp_pkg::*;

  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_accept;
  logic [63:0] out_result;
  fp_class_t   out_class;
  logic        err_short;
  logic        err_overrun;

  modport master (
    output in_data, in_ready, out_accept,
    input  out_valid, out_result, out_class, err_short, err_overrun
  );

  modport slave (
    input  in_data, in_ready, out_accept,
    output out_valid, out_result, out_class, err_short, err_overrun
  );

endinterface

// File: rtl/fp_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head data is valid whenever not empty.
// Push while full is honoured only if a pop happens in the same cycle.
module fp_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_result_collect.sv
// Reassembles 8-byte MSB-first multiplier bursts into 64-bit words, classifies them
// and queues them for the host; flags truncated bursts and words lost to a full FIFO.
module fp_result_collect
  import fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_result_collect_if.slave  bus
);

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_t;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BC_W  = $clog2(BYTES_PER_WORD);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);

  state_t          state_q, state_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic [55:0]     shreg_q, shreg_d;
  logic            word_done;
  logic            short_d;
  logic            overrun_d;
  logic            err_short_q;
  logic            err_overrun_q;

  logic [63:0]      word;
  fp_entry_t        push_entry;
  fp_entry_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             head_vld;
  logic             pop;
  logic             push_ok;

  // Only the low seven bytes are kept; the incoming byte completes the word.
  assign word = {shreg_q, bus.in_data};

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    short_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_ready) begin
          shreg_d = {shreg_q[47:0], bus.in_data};
          bcnt_d  = BC_W'(1);
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.in_ready) begin
          shreg_d = {shreg_q[47:0], bus.in_data};
          if (bcnt_q == LAST_BYTE) begin
            word_done = 1'b1;
            bcnt_d    = '0;
            state_d   = ST_IDLE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else begin
          short_d = 1'b1;
          bcnt_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        bcnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bcnt_q        <= '0;
      shreg_q       <= '0;
      err_short_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bcnt_q        <= bcnt_d;
      shreg_q       <= shreg_d;
      err_short_q   <= short_d;
      err_overrun_q <= overrun_d;
    end
  end

  assign head_vld  = (fifo_count != '0);
  assign pop       = head_vld && bus.out_accept;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_ok   = word_done && (!fifo_full || pop);
  assign overrun_d = word_done && !push_ok;

  assign push_entry = '{word: word, cls: classify(word[62:52], word[51:0])};

  fp_sync_fifo #(
    .WIDTH ($bits(fp_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_ok),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Storage is not reset, so the head is masked to zero while nothing is queued.
  assign bus.out_valid   = head_vld;
  assign bus.out_result  = fifo_empty ? 64'd0 : head.word;
  assign bus.out_class   = fifo_empty ? FP_ZERO : head.cls;
  assign bus.err_short   = err_short_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_fp_result_collect.sv
// Directed bench for fp_result_collect: expected words queued at stimulus time,
// a negedge monitor pops and compares whenever the host consumes the head.
module tb_fp_result_collect;
  import fp_pkg::*;

  typedef struct {
    logic [63:0] w;
    fp_class_t   c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_result_collect_if bus ();

  fp_result_collect #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_short = 0;
  int   n_ovr = 0;
  logic prev_short = 1'b0;
  logic prev_ovr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Monitor: scoreboard pops plus error-pulse counting and width checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.err_short) begin
        n_short++;
        chk("err_short_width", 64'(prev_short), 64'd0);
      end
      if (bus.err_overrun) begin
        n_ovr++;
        chk("err_overrun_width", 64'(prev_ovr), 64'd0);
      end
      if (bus.out_valid && bus.out_accept) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %h, expected no word", bus.out_result);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_result", bus.out_result, mon_e.w);
          chk("sb_class", 64'(bus.out_class), 64'(mon_e.c));
        end
      end
    end
    prev_short = bus.err_short;
    prev_ovr   = bus.err_overrun;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [63:0] w, input fp_class_t c);
    exp_t e;
    e.w = w;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic burst(input logic [63:0] w, input int nbytes, input logic acc_last);
    for (int i = 0; i < nbytes; i++) begin
      bus.in_ready = 1'b1;
      bus.in_data  = w[63 - 8*i -: 8];
      if (acc_last && i == 7) begin
        bus.out_accept = 1'b1;
      end
      tick();
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.in_ready   = 1'b0;
    bus.out_accept = 1'b1;
    while ((sb.size() != 0 || bus.out_valid) && t < 50) begin
      tick();
      t++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bus.in_data    = 8'h00;
    bus.in_ready   = 1'b0;
    bus.out_accept = 1'b0;
    rst_n          = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", bus.out_result, 64'd0);
    chk("rst_class", 64'(bus.out_class), 64'(FP_ZERO));
    chk("rst_err_short", 64'(bus.err_short), 64'd0);
    chk("rst_err_overrun", 64'(bus.err_overrun), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1.5 x 2.0 = 3.0: visible the cycle after byte 8, popped at once.
    bus.out_accept = 1'b1;
    expect_word(64'h4008000000000000, FP_NORM);
    burst(64'h4008000000000000, 8, 1'b0);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_result", bus.out_result, 64'h4008000000000000);
    chk("t1_class", 64'(bus.out_class), 64'(FP_NORM));
    bus.in_ready = 1'b0;
    tick();
    chk("t1_popped", 64'(bus.out_valid), 64'd0);

    // Three back-to-back bursts: INF, QNAN, SUB.
    expect_word(64'h7FF0000000000000, FP_INF);
    expect_word(64'hFFF8000000000001, FP_QNAN);
    expect_word(64'h0000000000000001, FP_SUB);
    burst(64'h7FF0000000000000, 8, 1'b0);
    burst(64'hFFF8000000000001, 8, 1'b0);
    burst(64'h0000000000000001, 8, 1'b0);
    drain();
    chk("t2_short_cnt", 64'(n_short), 64'd0);
    chk("t2_ovr_cnt", 64'(n_ovr), 64'd0);

    // Truncated burst, then a negative zero.
    burst(64'h1122334455667788, 5, 1'b0);
    bus.in_ready = 1'b0;
    tick();
    chk("t3_err_short", 64'(bus.err_short), 64'd1);
    chk("t3_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t3_err_short_off", 64'(bus.err_short), 64'd0);
    expect_word(64'h8000000000000000, FP_ZERO);
    burst(64'h8000000000000000, 8, 1'b0);
    drain();
    chk("t3_short_cnt", 64'(n_short), 64'd1);

    // Overrun: third word dropped while the host stalls.
    bus.out_accept = 1'b0;
    expect_word(64'h3FF0000000000000, FP_NORM);
    expect_word(64'h0010000000000000, FP_NORM);
    burst(64'h3FF0000000000000, 8, 1'b0);
    burst(64'h0010000000000000, 8, 1'b0);
    burst(64'h000FFFFFFFFFFFFF, 8, 1'b0);
    bus.in_ready = 1'b0;
    chk("t4_err_overrun", 64'(bus.err_overrun), 64'd1);
    chk("t4_head_hold", bus.out_result, 64'h3FF0000000000000);
    tick();
    chk("t4_err_overrun_off", 64'(bus.err_overrun), 64'd0);
    chk("t4_head_hold2", bus.out_result, 64'h3FF0000000000000);
    drain();
    chk("t4_ovr_cnt", 64'(n_ovr), 64'd1);

    // Full FIFO with a pop in the completing cycle: nothing lost.
    bus.out_accept = 1'b0;
    expect_word(64'hFFF0000000000000, FP_INF);
    expect_word(64'h7FEFFFFFFFFFFFFF, FP_NORM);
    expect_word(64'h7FF4000000000000, FP_SNAN);
    burst(64'hFFF0000000000000, 8, 1'b0);
    burst(64'h7FEFFFFFFFFFFFFF, 8, 1'b0);
    burst(64'h7FF4000000000000, 8, 1'b1);
    bus.in_ready = 1'b0;
    chk("t5_no_overrun", 64'(bus.err_overrun), 64'd0);
    drain();
    chk("t5_ovr_cnt", 64'(n_ovr), 64'd1);

    // Reset after four bytes discards the partial word silently.
    bus.out_accept = 1'b1;
    burst(64'h4000000000000000, 4, 1'b0);
    rst_n        = 1'b0;
    bus.in_ready = 1'b0;
    tick();
    tick();
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    expect_word(64'h7FF0000000000001, FP_SNAN);
    burst(64'h7FF0000000000001, 8, 1'b0);
    drain();
    chk("t6_short_cnt", 64'(n_short), 64'd1);
    chk("t6_ovr_cnt", 64'(n_ovr), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
